// File: rtl/pattern_gen.sv
// Free-running pattern source that steps one of four sequences: up, down, Gray view of an up count, or Galois LFSR.
// It also has enable, a synchronous seed load and a one-cycle wrap pulse; o_p and o_wrap are driven only from flops.
module pattern_gen #(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(16'hB400)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_p,
  output logic             o_wrap
);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_GRAY = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;
  logic [1:0]       mode_reg;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] step_value;
  logic             step_wraps;
  logic [WIDTH-1:0] gray_value;

  // One advance of the current state under the mode presented this cycle.
  always_comb begin
    step_value = state_reg;
    step_wraps = 1'b0;
    case (i_mode)
      MODE_UP, MODE_GRAY: begin
        step_value = state_reg + WIDTH'(1);
        step_wraps = (state_reg == '1);
      end
      MODE_DOWN: begin
        step_value = state_reg - WIDTH'(1);
        step_wraps = (state_reg == '0);
      end
      MODE_LFSR: begin
        // An all-zero LFSR would never leave zero, so it is kicked back to 1.
        if (state_reg == '0) begin
          step_value = WIDTH'(1);
        end else begin
          step_value = (state_reg >> 1) ^ (state_reg[0] ? TAPS : '0);
        end
        step_wraps = (step_value == WIDTH'(1));
      end
      default: begin
        step_value = state_reg;
        step_wraps = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    wrap_next  = 1'b0;
    if (i_load) begin
      state_next = i_seed;
    end else if (i_en) begin
      state_next = step_value;
      wrap_next  = step_wraps;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= RST_VAL;
      mode_reg  <= MODE_UP;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= i_mode;
      wrap_reg  <= wrap_next;
    end
  end

  // Gray view is formed from the registered count, so it lags i_mode by one cycle.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_value[gi] = state_reg[gi] ^ state_reg[gi+1];
    end
  endgenerate
  assign gray_value[WIDTH-1] = state_reg[WIDTH-1];

  assign o_p    = (mode_reg == MODE_GRAY) ? gray_value : state_reg;
  assign o_wrap = wrap_reg;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen at its default parameters.
// Directed scenarios and random traffic are compared with an arithmetic reference model of the sequences.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] seed = '0;
  logic [1:0]  mode = '0;
  logic [15:0] p;
  logic        wrap;

  int checks = 0;
  int failures = 0;
  bit verbose = 1'b1;

  // Reference model state: the counter value, the registered mode and the last wrap.
  int m_state = 1;
  int m_mode = 0;
  int m_wrap = 0;

  pattern_gen dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_load (load),
    .i_seed (seed),
    .i_mode (mode),
    .o_p    (p),
    .o_wrap (wrap)
  );

  always #5 clk = ~clk;

  function automatic int model_advance(input int s, input int md);
    case (md)
      0, 2: return (s + 1) % 65536;
      1: return (s + 65535) % 65536;
      default: begin
        if (s == 0) return 1;
        return (s / 2) ^ (((s % 2) == 1) ? 'hB400 : 0);
      end
    endcase
  endfunction

  // A wrap is recognised from where the sequence has landed.
  function automatic int model_landed_wrap(input int s_new, input int md);
    case (md)
      0, 2: return (s_new == 0) ? 1 : 0;
      1: return (s_new == 65535) ? 1 : 0;
      default: return (s_new == 1) ? 1 : 0;
    endcase
  endfunction

  function automatic logic [15:0] model_p();
    int v;
    v = (m_mode == 2) ? (m_state ^ (m_state / 2)) : m_state;
    return v[15:0];
  endfunction

  task automatic drive(input logic r, input logic l, input logic e,
                       input logic [15:0] sd, input logic [1:0] md);
    int nxt;
    rst = r; load = l; en = e; seed = sd; mode = md;
    @(posedge clk);
    if (r) begin
      m_state = 1; m_mode = 0; m_wrap = 0;
    end else begin
      m_mode = int'(md);
      if (l) begin
        m_state = int'(sd); m_wrap = 0;
      end else if (e) begin
        nxt = model_advance(m_state, int'(md));
        m_wrap = model_landed_wrap(nxt, int'(md));
        m_state = nxt;
      end else begin
        m_wrap = 0;
      end
    end
    #1;
    if (verbose)
      $display("txn t=%0t rst=%0b load=%0b en=%0b seed=%04h mode=%0d -> p=%04h wrap=%0b",
               $time, r, l, e, sd, md, p, wrap);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 16'h0, 2'd0);
    checks++;
    if (p !== 16'h0001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset p=%04h wrap=%0b expected p=0001 wrap=0", p, wrap);
    end
  endtask

  task automatic test_up_count();
    logic [15:0] exp_list [3] = '{16'h0002, 16'h0003, 16'h0004};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'h0, 2'd0);
      checks++;
      if (p !== exp_list[i] || wrap !== 1'b0 || p !== model_p()) begin
        failures++;
        $display("FAIL up_count step=%0d p=%04h wrap=%0b expected p=%04h wrap=0", i, p, wrap, exp_list[i]);
      end
    end
  endtask

  task automatic test_up_wrap_load();
    logic [15:0] exp_p [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic        exp_w [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 1, 1, 16'hFFFE, 2'd0);
      else drive(0, 0, 1, 16'h0, 2'd0);
      checks++;
      if (p !== exp_p[i] || wrap !== exp_w[i]) begin
        failures++;
        $display("FAIL up_wrap_load step=%0d p=%04h wrap=%0b expected p=%04h wrap=%0b",
                 i, p, wrap, exp_p[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [15:0] exp_p [4] = '{16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE};
    logic        exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(0, 1, 0, 16'h0001, 2'd1);
      else drive(0, 0, 1, 16'h0, 2'd1);
      checks++;
      if (p !== exp_p[i] || wrap !== exp_w[i]) begin
        failures++;
        $display("FAIL down_wrap step=%0d p=%04h wrap=%0b expected p=%04h wrap=%0b",
                 i, p, wrap, exp_p[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_gray();
    logic [15:0] exp_p [5] = '{16'h0004, 16'h000C, 16'h000D, 16'h000F, 16'h000A};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(0, 1, 0, 16'h0007, 2'd2);
      else if (i < 4) drive(0, 0, 1, 16'h0, 2'd2);
      else drive(0, 0, 0, 16'h0, 2'd0);
      checks++;
      if (p !== exp_p[i] || wrap !== 1'b0) begin
        failures++;
        $display("FAIL gray step=%0d p=%04h wrap=%0b expected p=%04h wrap=0", i, p, wrap, exp_p[i]);
      end
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] exp_p [6] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h0000, 16'h0001};
    logic        exp_w [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive(0, 1, 0, 16'h0001, 2'd3);
      else if (i == 4) drive(0, 1, 1, 16'h0000, 2'd3);
      else drive(0, 0, 1, 16'h0, 2'd3);
      checks++;
      if (p !== exp_p[i] || wrap !== exp_w[i]) begin
        failures++;
        $display("FAIL lfsr step=%0d p=%04h wrap=%0b expected p=%04h wrap=%0b",
                 i, p, wrap, exp_p[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_lfsr_full_run();
    int wraps = 0;
    int last_wrap_step = -1;
    int trace_err = 0;
    drive(0, 1, 0, 16'h0001, 2'd3);
    verbose = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(0, 0, 1, 16'h0, 2'd3);
      if (wrap === 1'b1) begin
        wraps++;
        last_wrap_step = i;
      end
      if (p !== model_p() || wrap !== m_wrap[0]) trace_err++;
    end
    verbose = 1'b1;
    $display("txn lfsr_full_run steps=65535 final p=%04h wraps=%0d", p, wraps);
    checks++;
    if (p !== 16'h0001 || wraps != 1 || last_wrap_step != 65534 || trace_err != 0) begin
      failures++;
      $display("FAIL lfsr_full_run p=%04h wraps=%0d wrap_step=%0d trace_err=%0d expected p=0001 wraps=1 wrap_step=65534 trace_err=0",
               p, wraps, last_wrap_step, trace_err);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [15:0] held;
    drive(0, 1, 0, 16'h5A5A, 2'd0);
    held = p;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 16'hFFFF, 2'd0);
      checks++;
      if (p !== 16'h5A5A || p !== held || wrap !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle=%0d p=%04h wrap=%0b expected p=5a5a wrap=0", i, p, wrap);
      end
    end
    drive(1, 1, 1, 16'h1234, 2'd2);
    checks++;
    if (p !== 16'h0001 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_over_load p=%04h wrap=%0b expected p=0001 wrap=0", p, wrap);
    end
  endtask

  task automatic test_random();
    logic [15:0] sd;
    logic        r, l, e;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: sd = 16'h0000;
        1: sd = 16'hFFFF;
        2: sd = 16'h0001;
        3: sd = 16'hFFFE;
        default: sd = 16'($urandom);
      endcase
      drive(r, l, e, sd, 2'($urandom_range(0, 3)));
      checks++;
      if (p !== model_p() || wrap !== m_wrap[0]) begin
        failures++;
        $display("FAIL random txn=%0d p=%04h wrap=%0b expected p=%04h wrap=%0b",
                 i, p, wrap, model_p(), m_wrap[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_up_wrap_load();
    test_down_wrap();
    test_gray();
    test_lfsr();
    test_hold_and_reset();
    test_random();
    test_lfsr_full_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised free-running pattern generator: successor to the fixed 16-bit generator, with configurable width, four selectable sequence modes (up, down, Gray, Galois LFSR), enable, synchronous seed load and a wrap pulse. Sits as a stimulus/sequence source feeding datapath blocks and benches, driven only by the system clock and reset plus a small control interface.

## Interface
- WIDTH, 16: state and output width; legal range 4..32.
- RST_VAL, 1: state value loaded by reset (WIDTH bits).
- TAPS, 16'hB400: Galois LFSR feedback mask (WIDTH bits); default is maximal-length for WIDTH=16.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_en  input  1  advance state by one step when high.
- i_load  input  1  load i_seed into state.
- i_seed  input  WIDTH  seed value for i_load.
- i_mode  input  2  0 = binary up, 1 = binary down, 2 = Gray count, 3 = Galois LFSR.
- o_p  output  WIDTH  current pattern value.
- o_wrap  output  1  one-cycle pulse: sequence wrapped on the step just taken.

## Operation
- Internal registers: state[WIDTH-1:0], mode_q[1:0], wrap_q.
- Per-edge priority: i_rst > i_load > i_en > hold.
- i_rst: state <= RST_VAL, mode_q <= 0, wrap_q <= 0.
- i_load: state <= i_seed, wrap_q <= 0; no advance that cycle, regardless of i_en.
- i_en (no load): state <= next(state, i_mode); wrap_q <= wrap condition; else state held, wrap_q <= 0.
- mode_q <= i_mode every non-reset cycle (independent of i_en/i_load).
- next(): mode 0: state+1 mod 2^WIDTH; mode 1: state-1 mod 2^WIDTH; mode 2: state+1 (binary counter underlying Gray view); mode 3: (state>>1) ^ (state[0] ? TAPS : 0).
- LFSR lock-up guard: mode 3 with state == 0 -> next = 1.
- Wrap condition: mode 0/2: state == all-ones; mode 1: state == 0; mode 3: next == 1.
- o_p = (mode_q == 2) ? state ^ (state>>1) : state; purely a function of flops, no combinational path from inputs.
- o_wrap = wrap_q.
- Mode change mid-sequence: state preserved, new mode governs next advance; Gray view of o_p applies from the cycle after i_mode changes.
- No illegal states; all 2^WIDTH state values reachable via load.

## Timing
- Reset values: o_p = RST_VAL (mode_q=0 -> raw), o_wrap = 0. Reset asserted for any single edge is sufficient.
- Latency: control/seed sampled at edge N, o_p reflects result after edge N (one-cycle).
- o_wrap high in exactly the cycle o_p first shows the wrapped value; never high two consecutive cycles unless wrap occurs on consecutive steps (impossible for WIDTH>=4 except mode 3 with TAPS producing period 1, unsupported).
- Reset mid-sequence: overrides load and enable on that edge; sequence resumes from RST_VAL.
- i_load and i_en together: load wins, next-cycle o_p = f(i_seed), advance resumes following cycle.
- i_en low: o_p stable except Gray/binary view switch on mode change.

## Test plan
- Reset/up count (WIDTH=16, defaults): i_rst 5 cycles -> o_p=16'h0001, o_wrap=0; release, i_mode=0, i_en=1 -> 0002, 0003, 0004 on successive cycles.
- Up wrap and load priority: i_load=1, i_en=1, i_seed=16'hFFFE for one cycle -> o_p=FFFE (no advance); then en -> FFFF, 0000 with o_wrap=1 only on the 0000 cycle.
- Down wrap: load 16'h0001, i_mode=1, en -> 0000, FFFF (o_wrap=1), FFFE (o_wrap=0).
- Gray: load 16'h0007, i_mode=2 -> o_p=0004; en -> 000C, 000D, 000F; drop i_en and set i_mode=0 -> o_p shows raw 000A next cycle.
- LFSR: load 16'h0001, i_mode=3, en -> B400, 5A00, 2D00; load 16'h0000 then en -> o_p=0001 with o_wrap=1; full run from 0001 returns to 0001 after 65535 steps with single o_wrap.
- Enable hold and mid-run reset: i_en=0 for 10 cycles -> o_p constant, o_wrap=0; assert i_rst together with i_load=1, i_seed=16'h1234 -> o_p=0001, mode view raw.
